mult_div_unit: RTL and testbench

- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
- Executes MTHI/MTLO in one cycle.
- Supplies the HI or LO value that travels down the pipeline as the MFHI/MFLO result, consumed by the writeback data select (select code 3).
- Exports busy so the hazard unit can stall later MD-class instructions.

---
 rtl/md_pkg.sv | 19 +
 rtl/md_calc.sv | 44 ++++
 rtl/mult_div_unit.sv | 80 ++++++++
 tb/tb_mult_div_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide encodings and default latencies.
// Imported by the MD unit and the decode/control logic.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath.
// Returns {hi,lo} and a divide-by-zero flag for ops 0..3.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        sgn;
  logic        is_div;
  logic [63:0] xa;
  logic [63:0] xb;
  logic [63:0] prod;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] dv;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  // Magnitude divide with sign fix-up; product on extended operands.
  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    is_div = is_md_div(op);
    xa     = {{32{sgn & a[31]}}, a};
    xb     = {{32{sgn & b[31]}}, b};
    prod   = xa * xb;
    ua     = (sgn && a[31]) ? -a : a;
    ub     = (sgn && b[31]) ? -b : b;
    dv     = (b == 32'd0) ? 32'd1 : ub;
    uq     = ua / dv;
    ur     = ua % dv;
    q      = (sgn && (a[31] ^ b[31])) ? -uq : uq;
    r      = (sgn && a[31]) ? -ur : ur;
    result = is_div ? {r, q} : prod;
    div_by_zero = is_div && (b == 32'd0);
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Fixed-latency MULT/DIV, single-cycle MTHI/MTLO.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [CW-1:0] count;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_dz;
  logic [63:0]   calc_res;
  logic          calc_dz;

  md_calc u_calc (
    .op          (md_op),
    .a           (rs_val),
    .b           (rt_val),
    .result      (calc_res),
    .div_by_zero (calc_dz)
  );

  assign busy   = (count != '0);
  assign md_out = rd_hi ? hi : lo;

  // Count down an in-flight op and commit; accept new ops when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else if (busy) begin
      count <= count - 1'b1;
      if (count == CW'(1) && !pend_dz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          pend_hi <= calc_res[63:32];
          pend_lo <= calc_res[31:0];
          pend_dz <= 1'b0;
          count   <= CW'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          pend_hi <= calc_res[63:32];
          pend_lo <= calc_res[31:0];
          pend_dz <= calc_dz;
          count   <= CW'(DIV_CYCLES);
        end
        MD_MTHI: hi <= rs_val;
        MD_MTLO: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Arithmetic model in plain longint math plus literal pins.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd7;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        rd_hi = 1'b0;
  logic        busy;
  logic [31:0] md_out;

  int checks = 0;
  int failures = 0;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .rd_hi  (rd_hi),
    .busy   (busy),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  bit          m_commit;
  int          m_left;

  function automatic logic [63:0] ref_op(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: return ua * ub;
      3'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_commit = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_commit) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end else if (start) begin
      if (md_op <= 3'd3) begin
        m_left   = (md_op <= 3'd1) ? 5 : 10;
        m_commit = !(md_op >= 3'd2 && rt_val == 0);
        if (m_commit) m_res = ref_op(md_op, rs_val, rt_val);
      end else if (md_op == 3'd4) m_hi = rs_val;
      else if (md_op == 3'd5) m_lo = rs_val;
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("busy_model", {31'd0, busy}, {31'd0, m_left != 0});
    check("md_out_model", md_out, rd_hi ? m_hi : m_lo);
  end

  task automatic drive(input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    start = 1'b0; md_op = 3'd7;
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_cycles);
    int n;
    drive(op, a, b);
    idle();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic read_hl(input string name,
                         input logic [31:0] eh, input logic [31:0] el);
    rd_hi = 1'b1; #1;
    check({name, "_hi"}, md_out, eh);
    rd_hi = 1'b0; #1;
    check({name, "_lo"}, md_out, el);
  endtask

  initial begin
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    read_hl("reset", 32'd0, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // MULT -2 * 3; old value visible while busy
    drive(3'd0, 32'hFFFFFFFE, 32'd3);
    idle();
    rd_hi = 1'b1; #1;
    check("mult_old_hi", md_out, 32'd0);
    check("mult_busy_rise", {31'd0, busy}, 32'd1);
    begin
      int n;
      n = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!busy) break;
        if (i > 0) n++;
      end
      check("mult_busy_cycles", 32'(n), 32'd5);
    end
    read_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    read_hl("multu", 32'hFFFFFFFE, 32'h00000001);

    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10);
    read_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    run_op("divu", 3'd3, 32'd7, 32'd2, 10);
    read_hl("divu", 32'd1, 32'd3);

    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10);
    read_hl("div_ovf", 32'd0, 32'h80000000);

    // MTHI/MTLO back to back
    @(posedge clk); #1;
    drive(3'd4, 32'h12345678, 32'd0);
    drive(3'd5, 32'h9ABCDEF0, 32'd0);
    idle();
    check("mt_busy", {31'd0, busy}, 32'd0);
    read_hl("mt", 32'h12345678, 32'h9ABCDEF0);

    // No-op codes leave state alone
    drive(3'd6, 32'hDEADBEEF, 32'd1);
    drive(3'd7, 32'hDEADBEEF, 32'd1);
    idle();
    check("nop_busy", {31'd0, busy}, 32'd0);
    read_hl("nop", 32'h12345678, 32'h9ABCDEF0);

    run_op("div0", 3'd2, 32'd100, 32'd0, 10);
    read_hl("div0", 32'h12345678, 32'h9ABCDEF0);
    run_op("divu0", 3'd3, 32'd100, 32'd0, 10);
    read_hl("divu0", 32'h12345678, 32'h9ABCDEF0);

    // Start while busy is ignored, then reset mid-op
    drive(3'd0, 32'h00010000, 32'h00010000);
    idle();
    @(posedge clk); #1;
    drive(3'd3, 32'd8, 32'd2);
    idle();
    check("busy_during_restart", {31'd0, busy}, 32'd1);
    read_hl("ignored_start", 32'h12345678, 32'h9ABCDEF0);
    reset = 1'b0; #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    read_hl("midreset", 32'd0, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_op("mult45", 3'd0, 32'd4, 32'd5, 5);
    read_hl("mult45", 32'd0, 32'd20);

    // Literal pins on the model itself
    check("model_mult", ref_op(3'd0, 32'hFFFFFFFE, 32'd3)[31:0],
          32'hFFFFFFFA);
    check("model_div_rem", ref_op(3'd2, 32'hFFFFFFF9, 32'd2)[63:32],
          32'hFFFFFFFF);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
